wb_burst_master: RTL and testbench

//  Wishbone master (initiator) that turns one command into a single or incremental-burst transfer.

---
 rtl/wb_burst_master_pkg.sv | 16 +
 rtl/wb_burst_master.sv | 244 ++++++++++++++++++++++++
 tb/tb_wb_burst_master.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_burst_master_pkg.sv
// rtl/wb_burst_master_pkg.sv - wishbone cycle-type constants and beat helpers shared by wb_burst_master
package wb_burst_master_pkg;

   localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
   localparam logic [2:0] WB_CTI_INCR    = 3'b010;
   localparam logic [2:0] WB_CTI_END     = 3'b111;
   localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;

   // Cycle type of the beat about to be presented on the bus.
   function automatic logic [2:0] beat_cti(input logic single, input logic last);
      if (single)    return WB_CTI_CLASSIC;
      else if (last) return WB_CTI_END;
      else           return WB_CTI_INCR;
   endfunction

endpackage

// File: rtl/wb_burst_master.sv
// rtl/wb_burst_master.sv - wishbone single/incrementing-burst master fed by a command and a write stream
// Define WB_MASTER_TIMEOUT_EN to abort a transfer after TIMEOUT_CYCLES strobed cycles without ack.
module wb_burst_master
   import wb_burst_master_pkg::*;
#(
   parameter int WB_ADDR_BITS   = 32,
   parameter int WORD_BYTES     = 4,
   parameter int LEN_BITS       = 4,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                      wbm_clk_i,
   input  logic                      wbm_rst_i,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_we,
   input  logic [WB_ADDR_BITS-3:0]   cmd_addr,
   input  logic [LEN_BITS-1:0]       cmd_len,
   input  logic                      wr_valid,
   output logic                      wr_ready,
   input  logic [8*WORD_BYTES-1:0]   wr_data,
   output logic                      rd_valid,
   output logic [8*WORD_BYTES-1:0]   rd_data,
   output logic                      rd_last,
   output logic                      done,
   output logic                      err,
   output logic                      wbm_cyc_o,
   output logic                      wbm_stb_o,
   output logic                      wbm_we_o,
   output logic [WB_ADDR_BITS-3:0]   wbm_addr_o,
   output logic [2:0]                wbm_cti_o,
   output logic [1:0]                wbm_bte_o,
   output logic [WORD_BYTES-1:0]     wbm_sel_o,
   output logic [8*WORD_BYTES-1:0]   wbm_data_o,
   input  logic [8*WORD_BYTES-1:0]   wbm_data_i,
   input  logic                      wbm_ack_i
);

   localparam int AW = WB_ADDR_BITS - 2;
   localparam int DW = 8 * WORD_BYTES;
   localparam logic [LEN_BITS:0] BL_ONE = (LEN_BITS + 1)'(1);
   localparam logic [LEN_BITS:0] BL_TWO = (LEN_BITS + 1)'(2);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_STALL  = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [AW-1:0]         addr_q, addr_d;
   logic [LEN_BITS:0]     bl_q, bl_d;
   logic                  cyc_q, cyc_d;
   logic                  stb_q, stb_d;
   logic                  we_q, we_d;
   logic [2:0]            cti_q, cti_d;
   logic [WORD_BYTES-1:0] sel_q, sel_d;
   logic [DW-1:0]         data_q, data_d;
   logic                  rd_valid_q, rd_valid_d;
   logic                  rd_last_q, rd_last_d;
   logic [DW-1:0]         rd_data_q, rd_data_d;
   logic                  done_q, done_d;
   logic                  cmd_ready_c, wr_ready_c;
   logic                  beat;

`ifdef WB_MASTER_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             err_q, err_d;
`else
   logic unused_tmo;
   assign unused_tmo = (TIMEOUT_CYCLES > 0);
`endif

   // A late ack arriving while stb is low belongs to no beat.
   assign beat = stb_q & wbm_ack_i;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      bl_d        = bl_q;
      cyc_d       = cyc_q;
      stb_d       = stb_q;
      we_d        = we_q;
      cti_d       = cti_q;
      sel_d       = sel_q;
      data_d      = data_q;
      rd_valid_d  = 1'b0;
      rd_last_d   = 1'b0;
      rd_data_d   = rd_data_q;
      done_d      = 1'b0;
      cmd_ready_c = 1'b0;
      wr_ready_c  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cmd_ready_c = 1'b1;
            wr_ready_c  = cmd_valid & cmd_we;
            if (cmd_valid) begin
               addr_d = cmd_addr;
               bl_d   = {1'b0, cmd_len} + BL_ONE;
               we_d   = cmd_we;
               sel_d  = '1;
               cyc_d  = 1'b1;
               cti_d  = beat_cti(cmd_len == '0, 1'b0);
               if (!cmd_we || wr_valid) begin
                  stb_d   = 1'b1;
                  state_d = ST_ACTIVE;
                  if (cmd_we) data_d = wr_data;
               end else begin
                  stb_d   = 1'b0;
                  state_d = ST_STALL;
               end
            end
         end
         ST_ACTIVE: begin
            if (beat) begin
               if (bl_q > BL_ONE) begin
                  addr_d = addr_q + AW'(1);
                  bl_d   = bl_q - BL_ONE;
                  cti_d  = beat_cti(1'b0, bl_q == BL_TWO);
                  if (!we_q) begin
                     rd_valid_d = 1'b1;
                     rd_data_d  = wbm_data_i;
                  end else begin
                     wr_ready_c = 1'b1;
                     if (wr_valid) begin
                        data_d = wr_data;
                     end else begin
                        stb_d   = 1'b0;
                        state_d = ST_STALL;
                     end
                  end
               end else begin
                  cyc_d   = 1'b0;
                  stb_d   = 1'b0;
                  cti_d   = WB_CTI_CLASSIC;
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
                  if (!we_q) begin
                     rd_valid_d = 1'b1;
                     rd_last_d  = 1'b1;
                     rd_data_d  = wbm_data_i;
                  end
               end
            end
         end
         ST_STALL: begin
            // Bus cycle stays owned while the write stream catches up.
            wr_ready_c = 1'b1;
            if (wr_valid) begin
               data_d  = wr_data;
               stb_d   = 1'b1;
               state_d = ST_ACTIVE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

`ifdef WB_MASTER_TIMEOUT_EN
      tmo_d = tmo_q;
      err_d = 1'b0;
      if (state_q != ST_ACTIVE || beat) begin
         tmo_d = '0;
      end else if (tmo_q == TMO_LAST) begin
         cyc_d      = 1'b0;
         stb_d      = 1'b0;
         cti_d      = WB_CTI_CLASSIC;
         err_d      = 1'b1;
         done_d     = 1'b0;
         rd_valid_d = 1'b0;
         rd_last_d  = 1'b0;
         state_d    = ST_IDLE;
         tmo_d      = '0;
      end else begin
         tmo_d = tmo_q + TMO_W'(1);
      end
`endif
   end

   always_ff @(posedge wbm_clk_i or posedge wbm_rst_i) begin
      if (wbm_rst_i) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         bl_q       <= '0;
         cyc_q      <= 1'b0;
         stb_q      <= 1'b0;
         we_q       <= 1'b0;
         cti_q      <= WB_CTI_CLASSIC;
         sel_q      <= '0;
         data_q     <= '0;
         rd_valid_q <= 1'b0;
         rd_last_q  <= 1'b0;
         rd_data_q  <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         bl_q       <= bl_d;
         cyc_q      <= cyc_d;
         stb_q      <= stb_d;
         we_q       <= we_d;
         cti_q      <= cti_d;
         sel_q      <= sel_d;
         data_q     <= data_d;
         rd_valid_q <= rd_valid_d;
         rd_last_q  <= rd_last_d;
         rd_data_q  <= rd_data_d;
         done_q     <= done_d;
      end
   end

`ifdef WB_MASTER_TIMEOUT_EN
   always_ff @(posedge wbm_clk_i or posedge wbm_rst_i) begin
      if (wbm_rst_i) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         tmo_q <= tmo_d;
         err_q <= err_d;
      end
   end
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   // Handshake readies are held low while reset is asserted.
   assign cmd_ready  = cmd_ready_c & ~wbm_rst_i;
   assign wr_ready   = wr_ready_c & ~wbm_rst_i;
   assign rd_valid   = rd_valid_q;
   assign rd_data    = rd_data_q;
   assign rd_last    = rd_last_q;
   assign done       = done_q;
   assign wbm_cyc_o  = cyc_q;
   assign wbm_stb_o  = stb_q;
   assign wbm_we_o   = we_q;
   assign wbm_addr_o = addr_q;
   assign wbm_cti_o  = cti_q;
   assign wbm_bte_o  = WB_BTE_LINEAR;
   assign wbm_sel_o  = sel_q;
   assign wbm_data_o = data_q;

endmodule

// File: tb/tb_wb_burst_master.sv
// tb/tb_wb_burst_master.sv - self-checking bench: wb_burst_master against a 4K-word wishbone RAM slave
module tb_wb_burst_master;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
   logic [29:0] cmd_addr = '0;
   logic [3:0]  cmd_len = '0;
   logic        wr_valid = 1'b0, wr_ready;
   logic [31:0] wr_data = '0;
   logic        rd_valid, rd_last, done, err;
   logic [31:0] rd_data;
   logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
   logic [29:0] wbm_addr_o;
   logic [2:0]  wbm_cti_o;
   logic [1:0]  wbm_bte_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_data_o, wbm_data_i;

   wb_burst_master #(.WB_ADDR_BITS(32), .WORD_BYTES(4), .LEN_BITS(4), .TIMEOUT_CYCLES(TMO)) dut (
      .wbm_clk_i(clk), .wbm_rst_i(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
      .done(done), .err(err),
      .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
      .wbm_addr_o(wbm_addr_o), .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
      .wbm_sel_o(wbm_sel_o), .wbm_data_o(wbm_data_o), .wbm_data_i(wbm_data_i),
      .wbm_ack_i(wbm_ack_i)
   );

   always #5 clk = ~clk;

   // RAM slave, 12-bit word address, ack in the same cycle as stb
   logic [31:0] mem [0:4095];
   logic        ack_en = 1'b1;
   logic        ghost = 1'b0;
   assign wbm_ack_i  = (wbm_cyc_o & wbm_stb_o & ack_en) | ghost;
   assign wbm_data_i = mem[wbm_addr_o[11:0]];
   always @(posedge clk)
      if (wbm_cyc_o && wbm_stb_o && wbm_ack_i && wbm_we_o) mem[wbm_addr_o[11:0]] <= wbm_data_o;

   int n_tests = 0, n_fail = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask

   // write-data source with a programmable gap and optional spurious acks
   logic [31:0] src[$];
   int          popped = 0, hold_idx = -1, hold_left = 0;
   logic        ghost_en = 1'b0, take;
   logic [31:0] junk;
   always begin
      @(negedge clk);
      take = wr_valid && wr_ready;
      @(posedge clk);
      #1;
      if (take && src.size() != 0) begin
         junk = src.pop_front();
         popped++;
      end
      if (popped == hold_idx && hold_left > 0) begin
         wr_valid = 1'b0;
         hold_left--;
      end else begin
         wr_valid = (src.size() != 0);
      end
      wr_data = (src.size() != 0) ? src[0] : 32'h0;
      ghost   = ghost_en && wbm_cyc_o && !wbm_stb_o;
   end

   // behavioural model: expected beat sequence, memory image and pulses
   logic [31:0] ref_mem [0:4095];
   logic [31:0] exp_w[$];
   logic [29:0] m_addr, exp_a;
   int          m_total = 0, m_beat = 0, cyc_n = 0, stbwait = 0, first_stb = -1;
   logic        m_we = 1'b0, exp_cyc = 1'b0;
   logic        rd_pend = 1'b0, done_pend = 1'b0, err_pend = 1'b0, rd_exp_last = 1'b0;
   logic [31:0] rd_exp_data = '0, w;
   logic [2:0]  exp_cti;
   int          done_cnt = 0, err_cnt = 0, done_cyc = 0, err_cyc = 0, stall_cnt = 0, ghost_cnt = 0;
   logic        rdy_at_err = 1'b0, cyc_at_err = 1'b1;
   logic [29:0] beat_addr_log[$];
   logic [2:0]  beat_cti_log[$];
   int          beat_cyc_log[$], rd_cyc_log[$];
   logic [31:0] rd_data_log[$];
   logic        rd_last_log[$];

   always @(negedge clk) begin
      cyc_n++;
      if (rst) begin
         exp_cyc = 1'b0; rd_pend = 1'b0; done_pend = 1'b0; err_pend = 1'b0;
         exp_w.delete();
         stbwait = 0;
      end else begin
         check("cyc", wbm_cyc_o, exp_cyc);
         check("rd_valid", rd_valid, rd_pend);
         if (rd_pend) begin
            check("rd_data", rd_data, rd_exp_data);
            check("rd_last", rd_last, rd_exp_last);
            rd_data_log.push_back(rd_data);
            rd_last_log.push_back(rd_last);
            rd_cyc_log.push_back(cyc_n);
         end
         check("done", done, done_pend);
         check("err", err, err_pend);
         if (done) begin done_cnt++; done_cyc = cyc_n; end
         if (err) begin err_cnt++; err_cyc = cyc_n; rdy_at_err = cmd_ready; cyc_at_err = wbm_cyc_o; end
         rd_pend = 1'b0; done_pend = 1'b0; err_pend = 1'b0;
         if (wr_valid && wr_ready) exp_w.push_back(wr_data);
         if (wbm_cyc_o && !wbm_stb_o) begin
            stall_cnt++;
            if (wbm_ack_i) ghost_cnt++;
         end
         if (cmd_valid && cmd_ready) begin
            m_addr = cmd_addr; m_total = int'(cmd_len) + 1; m_beat = 0; m_we = cmd_we;
            exp_cyc = 1'b1; stbwait = 0; first_stb = -1;
         end
         if (wbm_cyc_o && wbm_stb_o) begin
            if (first_stb < 0) first_stb = cyc_n;
            if (wbm_ack_i) begin
               exp_a   = m_addr + 30'(m_beat);
               exp_cti = (m_total == 1) ? 3'b000 : (m_beat == m_total - 1) ? 3'b111 : 3'b010;
               check("addr", wbm_addr_o, exp_a);
               check("we", wbm_we_o, m_we);
               check("sel", wbm_sel_o, 4'hF);
               check("bte", wbm_bte_o, 2'b00);
               check("cti", wbm_cti_o, exp_cti);
               beat_addr_log.push_back(wbm_addr_o);
               beat_cti_log.push_back(wbm_cti_o);
               beat_cyc_log.push_back(cyc_n);
               if (m_we) begin
                  check("wdata_avail", 64'(exp_w.size() != 0), 1);
                  if (exp_w.size() != 0) begin
                     w = exp_w.pop_front();
                     check("wdata", wbm_data_o, w);
                     ref_mem[exp_a[11:0]] = w;
                  end
               end else begin
                  rd_pend     = 1'b1;
                  rd_exp_data = ref_mem[exp_a[11:0]];
                  rd_exp_last = (m_beat == m_total - 1);
               end
               m_beat++;
               stbwait = 0;
               if (m_beat == m_total) begin done_pend = 1'b1; exp_cyc = 1'b0; end
            end else begin
               stbwait++;
`ifdef WB_MASTER_TIMEOUT_EN
               if (stbwait == TMO) begin err_pend = 1'b1; exp_cyc = 1'b0; end
`endif
            end
         end
      end
   end

   task automatic clear_logs();
      beat_addr_log.delete(); beat_cti_log.delete(); beat_cyc_log.delete();
      rd_data_log.delete(); rd_last_log.delete(); rd_cyc_log.delete();
      stall_cnt = 0; ghost_cnt = 0;
   endtask

   task automatic issue(input logic we, input logic [29:0] a, input int len);
      logic seen;
      seen = 1'b0;
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_len = 4'(len);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (cmd_ready) begin seen = 1'b1; break; end
      end
      check("cmd_accept", seen, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic run(input logic we, input logic [29:0] a, input int len, input string nm);
      int n0, k;
      n0 = done_cnt + err_cnt;
      clear_logs();
      issue(we, a, len);
      k = 0;
      while (done_cnt + err_cnt <= n0 && k < 400) begin @(posedge clk); k++; end
      check({nm, "_end"}, 64'(done_cnt + err_cnt > n0), 1);
   endtask

   initial begin
      int k, d0;
      for (int i = 0; i < 4096; i++) begin mem[i] = '0; ref_mem[i] = '0; end
      #3;
      check("rst_bus", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cti_o, wbm_bte_o, wbm_sel_o}, 0);
      check("rst_strm", {rd_valid, rd_last, done, err, cmd_ready, wr_ready}, 0);
      check("rst_addr_data", {wbm_addr_o, wbm_data_o, rd_data}, 0);
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      @(posedge clk); #1;
      check("ready_after_rst", cmd_ready, 1);

      // 4-beat write then read at 0x010
      for (int i = 0; i < 4; i++) src.push_back(32'hA0 + 32'(i));
      run(1'b1, 30'h010, 3, "w4");
      check("w4_nbeats", beat_cti_log.size(), 4);
      check("w4_cti", {beat_cti_log[0], beat_cti_log[1], beat_cti_log[2], beat_cti_log[3]}, 12'b010_010_010_111);
      check("w4_consec", 64'(beat_cyc_log[3] - beat_cyc_log[0]), 3);
      check("w4_done_lat", 64'(done_cyc - beat_cyc_log[3]), 1);
      run(1'b0, 30'h010, 3, "r4");
      for (int i = 0; i < 4; i++) check("r4_data", rd_data_log[i], 32'hA0 + 32'(i));
      check("r4_last", {rd_last_log[0], rd_last_log[1], rd_last_log[2], rd_last_log[3]}, 4'b0001);
      check("r4_consec", 64'(rd_cyc_log[3] - rd_cyc_log[0]), 3);
      check("r4_done_with_last", 64'(done_cyc - rd_cyc_log[3]), 0);

      // single beat at 0x3FF
      src.push_back(32'hDEADBEEF);
      run(1'b1, 30'h3FF, 0, "w1");
      check("w1_cti", beat_cti_log[0], 3'b000);
      run(1'b0, 30'h3FF, 0, "r1");
      check("r1_cti", beat_cti_log[0], 3'b000);
      check("r1_data", rd_data_log[0], 32'hDEADBEEF);
      check("r1_last", rd_last_log[0], 1);

      // 8-beat write with a 3-cycle gap before beat 3 and acks during the gap
      popped = 0; hold_idx = 2; hold_left = 3; ghost_en = 1'b1;
      for (int i = 0; i < 8; i++) src.push_back(32'h1000 + 32'(i));
      run(1'b1, 30'h100, 7, "w8");
      ghost_en = 1'b0; hold_idx = -1;
      check("w8_stall_cycles", stall_cnt, 3);
      check("w8_ghost_acks", ghost_cnt, 3);
      check("w8_nbeats", beat_addr_log.size(), 8);
      run(1'b0, 30'h100, 7, "r8");
      for (int i = 0; i < 8; i++) check("r8_data", rd_data_log[i], 32'h1000 + 32'(i));

      // 16-beat write across the top of the word address space
      for (int i = 0; i < 16; i++) src.push_back(32'h5000 + 32'(i));
      run(1'b1, 30'h3FFFFFFE, 15, "w16");
      check("w16_nbeats", beat_addr_log.size(), 16);
      check("w16_addr1", beat_addr_log[1], 30'h3FFFFFFF);
      check("w16_addr2", beat_addr_log[2], 30'h0);
      run(1'b0, 30'h3FFFFFFE, 15, "r16");
      for (int i = 0; i < 16; i++) check("r16_data", rd_data_log[i], 32'h5000 + 32'(i));

      // asynchronous reset in the middle of an 8-beat read
      clear_logs();
      d0 = done_cnt;
      issue(1'b0, 30'h100, 7);
      k = 0;
      while (beat_cyc_log.size() < 3 && k < 100) begin @(posedge clk); k++; end
      check("rst_mid_progress", 64'(beat_cyc_log.size() >= 3), 1);
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      check("rst_mid_cyc", wbm_cyc_o, 0);
      check("rst_mid_stb", wbm_stb_o, 0);
      @(negedge clk);
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      check("rst_mid_no_done", done_cnt, d0);
      run(1'b0, 30'h100, 7, "r8_after_rst");
      for (int i = 0; i < 8; i++) check("r8_after_rst_data", rd_data_log[i], 32'h1000 + 32'(i));

`ifdef WB_MASTER_TIMEOUT_EN
      ack_en = 1'b0;
      d0 = done_cnt;
      run(1'b0, 30'h020, 3, "tmo");
      ack_en = 1'b1;
      check("tmo_err_cnt", err_cnt, 1);
      check("tmo_latency", 64'(err_cyc - first_stb), 16);
      check("tmo_cyc", cyc_at_err, 0);
      check("tmo_ready", rdy_at_err, 1);
      check("tmo_no_done", done_cnt, d0);
      run(1'b0, 30'h010, 0, "r_after_tmo");
      check("r_after_tmo_data", rd_data_log[0], 32'hA0);
`endif

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
